// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU byte-output receiver.
package cpu_io_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int UART_FRAME_BITS      = 10;
endpackage

// File: rtl/cpu_out_if.sv
// CPU byte-output bus plus the receiver's UART/status outputs.
interface cpu_out_if #(
  parameter int DATAWIDTH  = 8,
  parameter int COUNTWIDTH = 16
);
  logic                  startIO;
  logic                  outFlag;
  logic [DATAWIDTH-1:0]  out;
  logic                  endFlag;
  logic                  tx;
  logic                  busy;
  logic                  overflow;
  logic                  done;
  logic [COUNTWIDTH-1:0] byteCount;

  modport master (output startIO, outFlag, out, endFlag,
                  input  tx, busy, overflow, done, byteCount);
  modport slave  (input  startIO, outFlag, out, endFlag,
                  output tx, busy, overflow, done, byteCount);
endinterface

// File: rtl/io_byte_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit.
module io_byte_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int FIFODEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 full,
  output logic                 empty
);
  localparam int AW = $clog2(FIFODEPTH);

  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic [AW:0]          wptr, rptr;
  logic                 do_pop, do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/cpu_out_receiver.sv
// Captures CPU output bytes on outFlag rising edges, queues them and sends
// each as a UART 8N1 frame; flags completion once endFlag is seen and drained.
module cpu_out_receiver
  import cpu_io_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int FIFODEPTH    = 16,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int COUNTWIDTH   = 16
) (
  input logic      clock,
  input logic      reset,
  cpu_out_if.slave io
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATAWIDTH - 1);

  tx_state_t             state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [BW-1:0]         bit_idx, bit_d;
  logic [DATAWIDTH-1:0]  shift, shift_d;
  logic                  flag_q, end_q, end_seen, ovf_q;
  logic [COUNTWIDTH-1:0] count_q;
  logic                  cap, fifo_pop, fifo_full, fifo_empty;
  logic [DATAWIDTH-1:0]  fifo_rdata;

  assign cap = io.startIO && io.outFlag && !flag_q;

  io_byte_fifo #(.DATAWIDTH(DATAWIDTH), .FIFODEPTH(FIFODEPTH)) u_fifo (
    .clock(clock), .reset(reset),
    .push(cap), .pop(fifo_pop), .wdata(io.out), .rdata(fifo_rdata),
    .full(fifo_full), .empty(fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flag_q   <= 1'b0;
      end_q    <= 1'b0;
      end_seen <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      flag_q <= io.outFlag;
      end_q  <= io.endFlag;
      if (io.startIO && io.endFlag && !end_q) end_seen <= 1'b1;
      if (cap) begin
        if (fifo_full && !fifo_pop) ovf_q <= 1'b1;
        else                        count_q <= count_q + COUNTWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bit_d    = bit_idx;
    shift_d  = shift;
    fifo_pop = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        shift_d  = fifo_rdata;
        cnt_d    = '0;
        state_d  = START;
      end
      START: if (cnt == CNT_LAST) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = DATA;
      end else cnt_d = cnt + CW'(1);
      DATA: if (cnt == CNT_LAST) begin
        cnt_d   = '0;
        shift_d = shift >> 1;
        if (bit_idx == BIT_LAST) state_d = STOP;
        else                     bit_d   = bit_idx + BW'(1);
      end else cnt_d = cnt + CW'(1);
      STOP: if (cnt == CNT_LAST) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else cnt_d = cnt + CW'(1);
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state register directly, so reset forces idle-high at once.
  assign io.tx        = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
  assign io.busy      = !fifo_empty || (state != IDLE);
  assign io.done      = end_seen && fifo_empty && (state == IDLE);
  assign io.overflow  = ovf_q;
  assign io.byteCount = count_q;
endmodule

// File: tb/tb_cpu_out_receiver.sv
// Directed + random bench; a queue/frame-timer model predicts every output each cycle.
module tb_cpu_out_receiver;
  import cpu_io_pkg::*;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = UART_FRAME_BITS * CPB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  cpu_out_if #(.DATAWIDTH(8), .COUNTWIDTH(16)) bus ();

  cpu_out_receiver #(.DATAWIDTH(8), .FIFODEPTH(DEPTH), .CLKS_PER_BIT(CPB), .COUNTWIDTH(16)) dut (
    .clock(clock), .reset(reset), .io(bus)
  );

  int errors = 0;
  int checks = 0;
  string phase = "init";

  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_txbusy, m_cnt;
  bit         m_flag_q, m_end_q, m_end_seen, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_txbusy = 0; m_cnt = 0; m_cur = '0;
    m_flag_q = 0; m_end_q = 0; m_end_seen = 0; m_ovf = 0;
  endtask

  task automatic check_outputs();
    logic ex_tx;
    int k, b;
    ex_tx = 1'b1;
    if (m_txbusy > 0) begin
      k = FRAME - m_txbusy;
      b = k / CPB;
      if (b == 0)                         ex_tx = 1'b0;
      else if (b == UART_FRAME_BITS - 1)  ex_tx = 1'b1;
      else                                ex_tx = m_cur[b-1];
    end
    chk("tx", 32'(bus.tx), 32'(ex_tx));
    chk("busy", 32'(bus.busy), 32'((m_q.size() > 0) || (m_txbusy > 0)));
    chk("done", 32'(bus.done), 32'(m_end_seen && m_q.size() == 0 && m_txbusy == 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("byteCount", 32'(bus.byteCount), 32'(m_cnt));
  endtask

  // One clock: evaluate model on pre-edge inputs, commit at the edge, compare at negedge.
  task automatic step();
    bit cap, endr, pop, in_rst, fl, ef;
    logic [7:0] d;
    in_rst = !reset;
    fl   = bus.outFlag;
    ef   = bus.endFlag;
    d    = bus.out;
    cap  = bus.startIO && fl && !m_flag_q;
    endr = bus.startIO && ef && !m_end_q;
    pop  = (m_txbusy == 0) && (m_q.size() > 0);
    @(posedge clock);
    if (in_rst) model_clear();
    else begin
      if (pop) begin m_cur = m_q.pop_front(); m_txbusy = FRAME; end
      else if (m_txbusy > 0) m_txbusy--;
      if (cap) begin
        if (m_q.size() < DEPTH) begin m_q.push_back(d); m_cnt = (m_cnt + 1) % 65536; end
        else m_ovf = 1;
      end
      if (endr) m_end_seen = 1;
      m_flag_q = fl;
      m_end_q  = ef;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    bus.out = b; bus.outFlag = 1'b1;
    run(hold);
    bus.outFlag = 1'b0;
    step();
  endtask

  initial begin
    bus.startIO = 1'b1; bus.outFlag = 1'b0; bus.out = '0; bus.endFlag = 1'b0;
    model_clear();
    #2 reset = 1'b0;

    phase = "reset";
    run(2);
    reset = 1'b1;
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_count", 32'(bus.byteCount), 32'd0);
    run(2);

    phase = "single";
    send(8'h41, 3);
    run(FRAME + 4);
    chk("t2_count", 32'(bus.byteCount), 32'd1);

    phase = "overflow";
    for (int i = 1; i <= 6; i++) send(8'(i), 1);
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    chk("t3_count", 32'(bus.byteCount), 32'd6);
    run(5 * (FRAME + 1) + 4);

    phase = "end";
    send(8'h55, 1);
    send(8'hAA, 1);
    bus.endFlag = 1'b1;
    step();
    chk("t4_done_early", 32'(bus.done), 32'd0);
    run(2 * (FRAME + 1));
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_busy", 32'(bus.busy), 32'd0);

    phase = "disabled";
    bus.startIO = 1'b0;
    send(8'hFF, 2);
    run(FRAME);
    chk("t5_count", 32'(bus.byteCount), 32'd8);
    bus.startIO = 1'b1;

    phase = "midreset";
    bus.endFlag = 1'b0;
    step();
    send(8'hC3, 1);
    run(17);
    #5 reset = 1'b0;
    #1;
    chk("t6_tx_async", 32'(bus.tx), 32'd1);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_count", 32'(bus.byteCount), 32'd0);
    model_clear();
    @(negedge clock);
    run(2);
    reset = 1'b1;
    step();
    send(8'h5A, 1);
    run(FRAME + 4);
    chk("t6_count_after", 32'(bus.byteCount), 32'd1);

    phase = "random";
    for (int n = 0; n < 25; n++) begin
      bus.startIO = ($urandom_range(0, 7) != 0);
      send(8'($urandom), $urandom_range(1, 3));
      run($urandom_range(1, 50));
    end
    bus.startIO = 1'b1;
    bus.endFlag = 1'b1;
    run((DEPTH + 1) * (FRAME + 1) + 4);
    chk("rand_done", 32'(bus.done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
